// File: rtl/wb_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : wb_arb_pkg
//  Description : Shared types and constants for the two-master Wishbone
//                register-bus arbiter: FSM state encoding, one-hot grant
//                encodings, default parameter values and a priority helper.
//  Revision    : 1.0  initial release
// ============================================================================
package wb_arb_pkg;

  // Arbiter FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } arb_state_e;

  // One-hot grant encodings; bit 0 is the AHB bridge, bit 1 the local master
  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_M0   = 2'b01;
  localparam logic [1:0] GNT_M1   = 2'b10;

  // Default configuration values
  localparam int          DEF_ADDRWIDTH  = 10;
  localparam int          DEF_DATAWIDTH  = 32;
  localparam int          DEF_TMO_CYCLES = 16;
  localparam logic [31:0] DEF_TMO_DATA   = 32'hDEAD_0E0E;

  // Priority after a completed transfer: it always moves to the master that
  // was not just served (0 = M0 holds priority, 1 = M1 holds priority).
  function automatic logic prio_after(input logic [1:0] served);
    return (served == GNT_M0);
  endfunction

endpackage : wb_arb_pkg
`default_nettype wire

// File: rtl/wb_arb_rr.sv
`default_nettype none
// ============================================================================
//  Module      : wb_arb_rr
//  Description : Two-way round-robin picker. A lone requester always wins;
//                on a tie the current priority holder wins. Purely
//                combinational, output is one-hot or zero.
//  Revision    : 1.0  initial release
// ============================================================================
module wb_arb_rr
  import wb_arb_pkg::*;
(
  input  logic [1:0] req,   // bit 0 = M0 request, bit 1 = M1 request
  input  logic       prio,  // 0 = M0 holds priority, 1 = M1 holds priority
  output logic [1:0] gnt    // one-hot pick, GNT_NONE when nobody asks
);

  // Pick the winner from the request pattern and the priority holder
  always_comb begin
    gnt = GNT_NONE;
    case (req)
      2'b01:   gnt = GNT_M0;
      2'b10:   gnt = GNT_M1;
      2'b11:   gnt = prio ? GNT_M1 : GNT_M0;
      default: gnt = GNT_NONE;
    endcase
  end

endmodule : wb_arb_rr
`default_nettype wire

// File: rtl/wb_reg_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : wb_reg_arbiter
//  Description : Two-master Wishbone arbiter in front of a shared register
//                slave. M0 is the AHB bridge, M1 the local master. One
//                transfer at a time: IDLE samples requests, BUSY passes the
//                granted master straight through to the slave, DONE inserts
//                one dead cycle. Round-robin priority rotates on completion.
//  Options     : WB_ARB_TIMEOUT_EN - adds an 8-bit BUSY-cycle watchdog that
//                terminates a stuck transfer with ACK+ERR and TMO_DATA and
//                sets a sticky status flag.
//  Revision    : 1.0  initial release
// ============================================================================
module wb_reg_arbiter
  import wb_arb_pkg::*;
#(
  parameter int                   ADDRWIDTH  = DEF_ADDRWIDTH,
  parameter int                   DATAWIDTH  = DEF_DATAWIDTH,
  parameter int                   TMO_CYCLES = DEF_TMO_CYCLES,
  parameter logic [DATAWIDTH-1:0] TMO_DATA   = DATAWIDTH'(DEF_TMO_DATA)
) (
  input  logic                 WBs_CLK_i,
  input  logic                 WBs_RST_i,

  // Master 0 (AHB bridge)
  input  logic [ADDRWIDTH-1:0] M0_ADR_i,
  input  logic                 M0_CYC_i,
  input  logic                 M0_STB_i,
  input  logic                 M0_WE_i,
  input  logic [3:0]           M0_BYTE_STB_i,
  input  logic [DATAWIDTH-1:0] M0_DAT_i,
  output logic [DATAWIDTH-1:0] M0_DAT_o,
  output logic                 M0_ACK_o,
  output logic                 M0_ERR_o,

  // Master 1 (local master)
  input  logic [ADDRWIDTH-1:0] M1_ADR_i,
  input  logic                 M1_CYC_i,
  input  logic                 M1_STB_i,
  input  logic                 M1_WE_i,
  input  logic [3:0]           M1_BYTE_STB_i,
  input  logic [DATAWIDTH-1:0] M1_DAT_i,
  output logic [DATAWIDTH-1:0] M1_DAT_o,
  output logic                 M1_ACK_o,
  output logic                 M1_ERR_o,

  // Shared register-slave bus
  output logic [ADDRWIDTH-1:0] S_ADR_o,
  output logic                 S_CYC_o,
  output logic                 S_STB_o,
  output logic                 S_WE_o,
  output logic [3:0]           S_BYTE_STB_o,
  output logic [DATAWIDTH-1:0] S_DAT_o,
  input  logic [DATAWIDTH-1:0] S_DAT_i,
  input  logic                 S_ACK_i,

  // Status
  output logic [1:0]           Gnt_o,
  output logic                 Tmo_Sticky_o,
  input  logic                 Tmo_Clr_i
);

  arb_state_e state;
  arb_state_e state_nxt;
  logic [1:0] gnt_q;
  logic [1:0] gnt_nxt;
  logic       prio_q;
  logic       prio_nxt;

  logic [1:0] req;
  logic [1:0] pick;
  logic       busy;
  logic       sel_m1;
  logic       own_cyc;
  logic       tmo_hit;
  logic       xfer_ack;
  logic       xfer_tmo;
  logic       ack_out;
  logic       err_out;
  logic [DATAWIDTH-1:0] rdata;

  assign req     = {M1_CYC_i & M1_STB_i, M0_CYC_i & M0_STB_i};
  assign busy    = (state == ST_BUSY);
  assign sel_m1  = gnt_q[1];
  assign own_cyc = sel_m1 ? M1_CYC_i : M0_CYC_i;

  wb_arb_rr u_rr (
    .req  (req),
    .prio (prio_q),
    .gnt  (pick)
  );

  // State, grant and priority registers
  always_ff @(posedge WBs_CLK_i) begin
    if (!WBs_RST_i) begin
      state  <= ST_IDLE;
      gnt_q  <= GNT_NONE;
      prio_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      gnt_q  <= gnt_nxt;
      prio_q <= prio_nxt;
    end
  end

  // Next-state logic: sample requests in IDLE, finish BUSY on abandon,
  // slave ACK or watchdog expiry (ACK beats the watchdog), one DONE cycle
  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt_q;
    prio_nxt  = prio_q;
    xfer_ack  = 1'b0;
    xfer_tmo  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (|req) begin
          gnt_nxt   = pick;
          state_nxt = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (!own_cyc) begin
          state_nxt = ST_DONE;
          gnt_nxt   = GNT_NONE;
          prio_nxt  = prio_after(gnt_q);
        end else if (S_ACK_i) begin
          xfer_ack  = 1'b1;
          state_nxt = ST_DONE;
          gnt_nxt   = GNT_NONE;
          prio_nxt  = prio_after(gnt_q);
        end else if (tmo_hit) begin
          xfer_tmo  = 1'b1;
          state_nxt = ST_DONE;
          gnt_nxt   = GNT_NONE;
          prio_nxt  = prio_after(gnt_q);
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
        gnt_nxt   = GNT_NONE;
      end
      default: begin
        state_nxt = ST_IDLE;
        gnt_nxt   = GNT_NONE;
      end
    endcase
  end

`ifdef WB_ARB_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TMO_CYCLES - 1);

  logic [7:0] tmo_cnt;
  logic       sticky_q;

  assign tmo_hit      = busy & (tmo_cnt == TMO_LAST);
  assign Tmo_Sticky_o = sticky_q;

  // BUSY-cycle counter; held at zero outside BUSY so every entry starts at 0
  always_ff @(posedge WBs_CLK_i) begin
    if (!WBs_RST_i) begin
      tmo_cnt <= 8'd0;
    end else if (!busy) begin
      tmo_cnt <= 8'd0;
    end else begin
      tmo_cnt <= tmo_cnt + 8'd1;
    end
  end

  // Sticky timeout flag; a new timeout wins over a clear in the same cycle
  always_ff @(posedge WBs_CLK_i) begin
    if (!WBs_RST_i) begin
      sticky_q <= 1'b0;
    end else if (xfer_tmo) begin
      sticky_q <= 1'b1;
    end else if (Tmo_Clr_i) begin
      sticky_q <= 1'b0;
    end
  end
`else
  // Without the watchdog BUSY waits for the slave forever
  logic [8:0] unused_tmo_cfg;

  assign tmo_hit        = 1'b0;
  assign Tmo_Sticky_o   = 1'b0;
  assign unused_tmo_cfg = {Tmo_Clr_i, 8'(TMO_CYCLES)};
`endif

  // Completion is suppressed while reset is low so an aborted transfer
  // never reaches a master
  assign ack_out = (xfer_ack | xfer_tmo) & WBs_RST_i;
  assign err_out = xfer_tmo & WBs_RST_i;
  assign rdata   = xfer_tmo ? TMO_DATA : S_DAT_i;

  assign M0_ACK_o = ack_out & gnt_q[0];
  assign M1_ACK_o = ack_out & gnt_q[1];
  assign M0_ERR_o = err_out & gnt_q[0];
  assign M1_ERR_o = err_out & gnt_q[1];
  assign M0_DAT_o = M0_ACK_o ? rdata : '0;
  assign M1_DAT_o = M1_ACK_o ? rdata : '0;

  // Slave bus follows the granted master only while BUSY
  assign S_CYC_o      = busy & (sel_m1 ? M1_CYC_i : M0_CYC_i);
  assign S_STB_o      = busy & (sel_m1 ? M1_STB_i : M0_STB_i);
  assign S_WE_o       = busy & (sel_m1 ? M1_WE_i  : M0_WE_i);
  assign S_ADR_o      = busy ? (sel_m1 ? M1_ADR_i      : M0_ADR_i)      : '0;
  assign S_BYTE_STB_o = busy ? (sel_m1 ? M1_BYTE_STB_i : M0_BYTE_STB_i) : 4'h0;
  assign S_DAT_o      = busy ? (sel_m1 ? M1_DAT_i      : M0_DAT_i)      : '0;

  assign Gnt_o = busy ? gnt_q : GNT_NONE;

endmodule : wb_reg_arbiter
`default_nettype wire
